variable_latency_ini_throttle: RTL and testbench

- Initiator-side admission controller placed between the cores and the variable-latency TCDM interconnect request ports.
- Tracks outstanding transactions per initiator, with a runtime-programmable cap, and gates the request valid/ready handshake accordingly.
- Provides a global drain/quiesce handshake so software or a reconfiguration controller can empty the interconnect before changing bank mapping or power state.
- Handshake-only: address, data, wen and be bypass this block.

---
 rtl/variable_latency_ini_throttle.sv | 146 ++++++++++++++
 tb/tb_variable_latency_ini_throttle.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/variable_latency_ini_throttle.sv
// variable_latency_ini_throttle
//
// Initiator-side admission controller that sits between the cores and the
// request ports of a variable-latency TCDM interconnect. It counts
// outstanding transactions per initiator, caps them at a runtime limit, and
// offers a global drain/quiesce handshake. Only the request valid/ready
// handshake passes through here; address, data, wen and be bypass it.
//
// Handshake: a request transfers on a cycle where valid and ready are both
// high. Once req_valid_o[i] is raised it stays high until that transfer
// happens, even if the cap is lowered or a drain starts in the meantime. The
// initiator is expected to hold req_valid_i stable until req_ready_o is seen.
//
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   cfg_limit_i     runtime cap; effective cap = min(cfg_limit_i, MaxOutstanding)
//   drain_req_i     level request to quiesce the interconnect
//   drain_ack_o     high while drained (nothing outstanding, admission closed)
//   req_valid_i/req_ready_o  initiator side of the request handshake
//   req_valid_o/req_ready_i  interconnect side of the request handshake
//   resp_valid_i/resp_ready_i  response handshake, monitored only
//   busy_o          per-initiator nonzero outstanding count (registered)
//   err_o           sticky: a response arrived while the count was zero
//   dbg_state_o     current drain FSM state (0 RUN, 1 DRAIN, 2 DRAINED)

module variable_latency_ini_throttle #(
  parameter int NumIn          = 32,
  parameter int MaxOutstanding = 4,
  parameter int CntWidth       = $clog2(MaxOutstanding + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [CntWidth-1:0] cfg_limit_i,
  input  logic                drain_req_i,
  output logic                drain_ack_o,
  input  logic [NumIn-1:0]    req_valid_i,
  output logic [NumIn-1:0]    req_ready_o,
  output logic [NumIn-1:0]    req_valid_o,
  input  logic [NumIn-1:0]    req_ready_i,
  input  logic [NumIn-1:0]    resp_valid_i,
  input  logic [NumIn-1:0]    resp_ready_i,
  output logic [NumIn-1:0]    busy_o,
  output logic                err_o,
  output logic [1:0]          dbg_state_o
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_DRAINED = 2'd2
  } state_e;

  localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxOutstanding);

  state_e              state_q, state_d;
  logic [CntWidth-1:0] cnt_q [NumIn];
  logic [CntWidth-1:0] cnt_d [NumIn];
  logic [NumIn-1:0]    hold_q, hold_d;
  logic [NumIn-1:0]    busy_q, busy_d;
  logic [NumIn-1:0]    allow;
  logic [NumIn-1:0]    req_fire, resp_fire;
  logic                err_q, err_d;
  logic                drain_ack_q;
  logic                all_idle;
  logic [CntWidth-1:0] eff_cap;

  assign eff_cap = (cfg_limit_i > MaxCnt) ? MaxCnt : cfg_limit_i;

  // allow depends only on registered state and the static cap, so there is
  // no combinational path from req_ready_i to req_valid_o.
  always_comb begin
    all_idle = (hold_q == '0);
    allow    = '0;
    for (int i = 0; i < NumIn; i++) begin
      allow[i] = hold_q[i] | ((state_q == ST_RUN) & (cnt_q[i] < eff_cap));
      if (cnt_q[i] != '0) all_idle = 1'b0;
    end
  end

  assign req_valid_o = req_valid_i & allow;
  assign req_ready_o = req_ready_i & allow;
  assign req_fire    = req_valid_o & req_ready_i;
  assign resp_fire   = resp_valid_i & resp_ready_i;

  // A presented-but-stalled request keeps its admission next cycle.
  assign hold_d = req_valid_o & ~req_ready_i;

  always_comb begin
    err_d  = err_q;
    busy_d = '0;
    for (int i = 0; i < NumIn; i++) begin
      cnt_d[i] = cnt_q[i];
      if (req_fire[i] && !resp_fire[i]) begin
        // Saturate defensively; a held request was admitted below the cap.
        if (cnt_q[i] != MaxCnt) cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (resp_fire[i] && !req_fire[i]) begin
        if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - 1'b1;
      end
      // A response with nothing counted is an error even if a new request
      // fires in the same cycle; the count is then left unchanged.
      if (resp_fire[i] && (cnt_q[i] == '0)) err_d = 1'b1;
      busy_d[i] = (cnt_d[i] != '0);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (drain_req_i) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!drain_req_i)  state_d = ST_RUN;
        else if (all_idle) state_d = ST_DRAINED;
      end
      ST_DRAINED: begin
        if (!drain_req_i) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_RUN;
      hold_q      <= '0;
      busy_q      <= '0;
      err_q       <= 1'b0;
      drain_ack_q <= 1'b0;
      for (int i = 0; i < NumIn; i++) cnt_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      drain_ack_q <= (state_d == ST_DRAINED);
      for (int i = 0; i < NumIn; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign drain_ack_o = drain_ack_q;
  assign busy_o      = busy_q;
  assign err_o       = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_variable_latency_ini_throttle.sv
// Testbench for variable_latency_ini_throttle.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. Expected values are pushed to exp_q when a scenario step is
// driven and popped when the corresponding DUT output is sampled.

module tb_variable_latency_ini_throttle;

  localparam int NumIn    = 32;
  localparam int MaxOut   = 4;
  localparam int CntWidth = 3;

  logic                clk_i = 1'b0;
  logic                rst_ni;
  logic [CntWidth-1:0] cfg_limit_i;
  logic                drain_req_i;
  logic                drain_ack_o;
  logic [NumIn-1:0]    req_valid_i;
  logic [NumIn-1:0]    req_ready_o;
  logic [NumIn-1:0]    req_valid_o;
  logic [NumIn-1:0]    req_ready_i;
  logic [NumIn-1:0]    resp_valid_i;
  logic [NumIn-1:0]    resp_ready_i;
  logic [NumIn-1:0]    busy_o;
  logic                err_o;
  logic [1:0]          dbg_state_o;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic        done     = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  variable_latency_ini_throttle #(
    .NumIn(NumIn),
    .MaxOutstanding(MaxOut),
    .CntWidth(CntWidth)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .cfg_limit_i(cfg_limit_i),
    .drain_req_i(drain_req_i),
    .drain_ack_o(drain_ack_o),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_valid_o(req_valid_o),
    .req_ready_i(req_ready_i),
    .resp_valid_i(resp_valid_i),
    .resp_ready_i(resp_ready_i),
    .busy_o(busy_o),
    .err_o(err_o),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- checking / scoreboard ----------------
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic exp_push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic exp_pop_check(input string tag, input logic [31:0] got);
    logic [31:0] e;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    check_val(tag, got, e);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic count_fires(input int n, input int idx, output int fires);
    fires = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk_i);
      if (req_valid_o[idx] && req_ready_i[idx]) fires++;
      tick();
    end
  endtask

  task automatic pulse_resp(input logic [NumIn-1:0] mask, input int cycles);
    resp_valid_i = mask;
    resp_ready_i = mask;
    repeat (cycles) tick();
    resp_valid_i = '0;
    resp_ready_i = '0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #50000;
    check_val("watchdog_done", {31'd0, done}, 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    int   f;
    logic ack_seen;

    rst_ni       = 1'b0;
    cfg_limit_i  = 3'd4;
    drain_req_i  = 1'b0;
    req_valid_i  = '0;
    req_ready_i  = '0;
    resp_valid_i = '0;
    resp_ready_i = '0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // Reset state
    @(negedge clk_i);
    exp_push(0); exp_pop_check("rst_ack", {31'd0, drain_ack_o});
    exp_push(0); exp_pop_check("rst_err", {31'd0, err_o});
    exp_push(0); exp_pop_check("rst_busy", busy_o);
    exp_push(0); exp_pop_check("rst_state", {30'd0, dbg_state_o});
    tick();

    // Cap = 2 on initiator 0, no responses: exactly two fires
    cfg_limit_i    = 3'd2;
    req_valid_i[0] = 1'b1;
    req_ready_i[0] = 1'b1;
    exp_push(2);
    count_fires(6, 0, f);
    exp_pop_check("cap_fires", f);
    @(negedge clk_i);
    exp_push(0); exp_pop_check("cap_ready_o0", {31'd0, req_ready_o[0]});
    exp_push(1); exp_pop_check("cap_busy0", {31'd0, busy_o[0]});
    tick();
    pulse_resp(32'h1, 1);
    exp_push(1);
    count_fires(5, 0, f);
    exp_pop_check("cap_refire", f);
    req_valid_i[0] = 1'b0;                 // cnt0 = 2

    // Simultaneous request and response fire with cnt = 1
    req_valid_i[1] = 1'b1;
    req_ready_i[1] = 1'b1;
    tick();
    req_valid_i[1]  = 1'b1;
    resp_valid_i[1] = 1'b1;
    resp_ready_i[1] = 1'b1;
    @(negedge clk_i);
    exp_push(1); exp_pop_check("sim_fire", {31'd0, req_valid_o[1] & req_ready_i[1]});
    tick();
    resp_valid_i[1] = 1'b0;
    resp_ready_i[1] = 1'b0;
    req_valid_i[1]  = 1'b0;
    @(negedge clk_i);
    exp_push(1); exp_pop_check("sim_busy1", {31'd0, busy_o[1]});
    exp_push(0); exp_pop_check("sim_err", {31'd0, err_o});
    tick();
    req_valid_i[1] = 1'b1;
    exp_push(1);                           // cnt1 was 1, cap 2: one more fire
    count_fires(4, 1, f);
    exp_pop_check("sim_cnt_kept", f);
    req_valid_i = '0;
    req_ready_i = '0;
    pulse_resp(32'h3, 2);
    @(negedge clk_i);
    exp_push(0); exp_pop_check("cleanup_busy", busy_o);
    tick();

    // Valid hold across a cap drop to 0
    cfg_limit_i    = 3'd1;
    req_valid_i[2] = 1'b1;
    req_ready_i[2] = 1'b0;
    @(negedge clk_i);
    exp_push(1); exp_pop_check("hold_v0", {31'd0, req_valid_o[2]});
    tick();
    cfg_limit_i = 3'd0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      exp_push(1); exp_pop_check("hold_v", {31'd0, req_valid_o[2]});
      tick();
    end
    req_ready_i[2] = 1'b1;
    @(negedge clk_i);
    exp_push(1); exp_pop_check("hold_fire_v", {31'd0, req_valid_o[2]});
    exp_push(1); exp_pop_check("hold_fire_r", {31'd0, req_ready_o[2]});
    tick();
    @(negedge clk_i);
    exp_push(0); exp_pop_check("hold_after_v", {31'd0, req_valid_o[2]});
    exp_push(1); exp_pop_check("hold_after_busy", {31'd0, busy_o[2]});
    tick();
    req_valid_i = '0;
    req_ready_i = '0;
    pulse_resp(32'h4, 1);
    cfg_limit_i = 3'd4;

    // Drain with initiators 0 and 3 holding two outstanding each
    req_valid_i = 32'h9;
    req_ready_i = 32'h9;
    tick();
    tick();
    req_valid_i = '0;
    drain_req_i = 1'b1;
    @(negedge clk_i);
    exp_push(32'h9); exp_pop_check("drain_busy", busy_o);
    tick();
    req_valid_i = 32'h9;                   // keep asking; nothing may fire
    for (int k = 0; k < 4; k++) begin
      resp_valid_i = (k < 2) ? 32'h1 : 32'h8;
      resp_ready_i = resp_valid_i;
      @(negedge clk_i);
      exp_push(0); exp_pop_check("drain_nofire", req_valid_o & req_ready_i);
      exp_push(0); exp_pop_check("drain_ack_low", {31'd0, drain_ack_o});
      tick();
    end
    resp_valid_i = '0;
    resp_ready_i = '0;
    @(negedge clk_i);
    exp_push(0); exp_pop_check("drain_ack_t1", {31'd0, drain_ack_o});
    exp_push(1); exp_pop_check("drain_state_t1", {30'd0, dbg_state_o});
    tick();
    @(negedge clk_i);
    exp_push(1); exp_pop_check("drain_ack_t2", {31'd0, drain_ack_o});
    exp_push(2); exp_pop_check("drain_state_t2", {30'd0, dbg_state_o});
    exp_push(0); exp_pop_check("drained_valid_o", req_valid_o);
    tick();
    drain_req_i = 1'b0;
    @(negedge clk_i);
    exp_push(1); exp_pop_check("drained_ack_hold", {31'd0, drain_ack_o});
    tick();
    @(negedge clk_i);
    exp_push(0); exp_pop_check("resume_ack", {31'd0, drain_ack_o});
    exp_push(32'h9); exp_pop_check("resume_valid_o", req_valid_o);
    tick();
    req_valid_i = '0;
    req_ready_i = '0;
    pulse_resp(32'h9, 1);

    // Drain abort: request high for one cycle while outstanding
    req_valid_i[4] = 1'b1;
    req_ready_i[4] = 1'b1;
    tick();
    req_valid_i[4] = 1'b0;
    drain_req_i    = 1'b1;
    tick();
    drain_req_i = 1'b0;
    ack_seen    = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      ack_seen = ack_seen | drain_ack_o;
      tick();
    end
    exp_push(0); exp_pop_check("abort_no_ack", {31'd0, ack_seen});
    @(negedge clk_i);
    exp_push(0); exp_pop_check("abort_state", {30'd0, dbg_state_o});
    tick();
    req_valid_i[4] = 1'b1;
    @(negedge clk_i);
    exp_push(1); exp_pop_check("abort_admit", {31'd0, req_valid_o[4]});
    tick();
    req_valid_i = '0;
    req_ready_i = '0;
    pulse_resp(32'h10, 2);

    // Drain requested while idle: ack two cycles after the request
    drain_req_i = 1'b1;
    @(negedge clk_i);
    exp_push(0); exp_pop_check("idle_ack_c0", {31'd0, drain_ack_o});
    tick();
    @(negedge clk_i);
    exp_push(0); exp_pop_check("idle_ack_c1", {31'd0, drain_ack_o});
    tick();
    @(negedge clk_i);
    exp_push(1); exp_pop_check("idle_ack_c2", {31'd0, drain_ack_o});
    tick();
    drain_req_i = 1'b0;
    tick();
    tick();

    // Underflow on initiator 5, then asynchronous reset
    pulse_resp(32'h20, 1);
    @(negedge clk_i);
    exp_push(1); exp_pop_check("err_set", {31'd0, err_o});
    tick();
    repeat (3) tick();
    @(negedge clk_i);
    exp_push(1); exp_pop_check("err_sticky", {31'd0, err_o});
    tick();
    req_valid_i[6] = 1'b1;
    req_ready_i[6] = 1'b1;
    tick();
    req_valid_i = '0;
    req_ready_i = '0;
    @(negedge clk_i);
    exp_push(1); exp_pop_check("pre_rst_busy6", {31'd0, busy_o[6]});
    #2 rst_ni = 1'b0;
    #1;
    exp_push(0); exp_pop_check("async_rst_err", {31'd0, err_o});
    exp_push(0); exp_pop_check("async_rst_busy", busy_o);
    exp_push(0); exp_pop_check("async_rst_ack", {31'd0, drain_ack_o});
    exp_push(0); exp_pop_check("async_rst_state", {30'd0, dbg_state_o});
    #3 rst_ni = 1'b1;
    tick();

    // ---------------- final report ----------------
    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
